// File: rtl/sha_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks with the
// 0x80 terminator and the 64-bit big-endian bit length appended.
module sha_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  output logic         blk_last,
  input  logic         blk_ready
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] EMIT  = 2'd1;
  localparam logic [1:0] EXTRA = 2'd2;

  // ext encodes the trailing block still owed after the current one:
  // 0 = none, 1 = length-only block, 2 = block starting with 0x80.
  localparam logic [1:0] EXT_NONE = 2'd0;
  localparam logic [1:0] EXT_LEN  = 2'd1;
  localparam logic [1:0] EXT_PAD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [511:0]     buf_q, buf_d;
  logic             last_q, last_d;
  logic [1:0]       ext_q, ext_d;

  logic             beat;
  logic             data_wr;
  logic [6:0]       cnt;

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == EMIT);
  assign blk_data  = buf_q;
  assign blk_last  = last_q;

  assign beat    = in_valid & in_ready;
  assign data_wr = beat & ~in_empty;
  // Bytes occupied once this beat lands; 64 means the block is full of data.
  assign cnt     = {1'b0, idx_q} + {6'd0, data_wr};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    buf_d   = buf_q;
    last_d  = last_q;
    ext_d   = ext_q;

    case (state_q)
      FILL: begin
        if (beat) begin
          if (data_wr) begin
            idx_d = idx_q + 6'd1;
            len_d = len_q + LEN_W'(8);
            for (int b = 0; b < 64; b++) begin
              if (idx_q == 6'(b)) buf_d[511-8*b -: 8] = in_data;
            end
          end

          if (in_last) begin
            state_d = EMIT;
            for (int b = 0; b < 64; b++) begin
              if (cnt == 7'(b)) buf_d[511-8*b -: 8] = 8'h80;
            end
            if (cnt <= 7'd55) begin
              buf_d[63:0] = 64'(len_d);
              last_d      = 1'b1;
              ext_d       = EXT_NONE;
            end else if (cnt == 7'd64) begin
              last_d = 1'b0;
              ext_d  = EXT_PAD;
            end else begin
              last_d = 1'b0;
              ext_d  = EXT_LEN;
            end
          end else if (data_wr && idx_q == 6'd63) begin
            state_d = EMIT;
            last_d  = 1'b0;
            ext_d   = EXT_NONE;
          end
        end
      end

      EMIT: begin
        if (blk_ready) begin
          buf_d  = '0;
          idx_d  = '0;
          last_d = 1'b0;
          if (ext_q == EXT_NONE) begin
            state_d = FILL;
            // A final block closes the message; the next one counts from zero.
            if (last_q) len_d = '0;
          end else begin
            state_d = EXTRA;
          end
        end
      end

      EXTRA: begin
        buf_d[511:504] = (ext_q == EXT_PAD) ? 8'h80 : 8'h00;
        buf_d[63:0]    = 64'(len_q);
        last_d         = 1'b1;
        ext_d          = EXT_NONE;
        state_d        = EMIT;
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      ext_q   <= EXT_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      ext_q   <= ext_d;
    end
  end

endmodule

// File: tb/tb_sha_padder.sv
// Bench for sha_padder: directed scenarios plus randomized messages checked
// against a queue-based FIPS 180-4 padding model.
module tb_sha_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;

  sha_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] data;
    logic         last;
    int           rise;
    int           hs;
  } blk_t;

  blk_t         got_q[$];
  logic [511:0] exp_q[$];
  logic [7:0]   msg[$];
  int           acc_q[$];
  int           n_asserts = 0;
  int           n_fail    = 0;
  bit           rbp       = 1'b0;
  int           last_acc  = 0;

  // Block monitor: samples mid-cycle, records each handshake.
  logic prev_valid = 1'b0;
  int   cur_rise   = 0;
  always @(negedge clk) begin
    if (blk_valid && !prev_valid) cur_rise = cyc;
    if (blk_valid && blk_ready) got_q.push_back('{blk_data, blk_last, cur_rise, cyc + 1});
    prev_valid = blk_valid;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rbp) blk_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
    int w = 0;
    in_data  = d;
    in_last  = last;
    in_empty = empty;
    in_valid = 1'b1;
    while (!in_ready && w < 400) begin
      step();
      w++;
    end
    chk("beat_timeout", 512'(w < 400), 512'(1));
    last_acc = cyc + 1;
    acc_q.push_back(last_acc);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic send_msg(input bit gaps);
    int  n    = msg.size();
    bit  trail = (n > 0) && gaps && ($urandom_range(0, 3) == 0);
    got_q.delete();
    acc_q.delete();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
      if (gaps && $urandom_range(0, 7) == 0) send_beat(8'($urandom), 1'b0, 1'b1);
      send_beat(msg[i], (i == n - 1) && !trail, 1'b0);
    end
    if (n == 0 || trail) send_beat(8'($urandom), 1'b1, 1'b1);
  endtask

  // Reference: pad per FIPS 180-4 on a byte list, then slice into blocks.
  task automatic build_exp();
    logic [7:0]  p[$];
    logic [63:0] bits;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      logic [511:0] v = '0;
      for (int j = 0; j < 64; j++) v = {v[503:0], p[64*b + j]};
      exp_q.push_back(v);
    end
  endtask

  task automatic drain_check(input string tag);
    int w = 0;
    while (got_q.size() < exp_q.size() && w < 2000) begin
      step();
      w++;
    end
    repeat (4) step();
    chk({tag, "_count"}, 512'(got_q.size()), 512'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i]);
        chk($sformatf("%s_last%0d", tag, i), 512'(got_q[i].last), 512'(i == exp_q.size() - 1));
      end
    end
    $display("txn %s: %0d bytes, %0d blocks expected, %0d received", tag, msg.size(), exp_q.size(), got_q.size());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 512'(in_ready), 512'(1));
    chk({tag, "_blk_valid"}, 512'(blk_valid), 512'(0));
    chk({tag, "_blk_last"}, 512'(blk_last), 512'(0));
    chk({tag, "_blk_data"}, blk_data, 512'(0));
  endtask

  initial begin
    logic [511:0] abc_blk;
    logic [511:0] ref_blk;
    logic [511:0] d0;
    logic         l0;

    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;

    rst = 1'b1;
    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // "abc"
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    build_exp();
    drain_check("abc");
    chk("abc_const", got_q[0].data, abc_blk);
    chk("abc_latency", 512'(got_q[0].rise), 512'(last_acc));

    // Empty message
    msg.delete();
    send_msg(1'b0);
    build_exp();
    drain_check("empty");
    ref_blk = '0;
    ref_blk[511:504] = 8'h80;
    chk("empty_const", got_q[0].data, ref_blk);

    // 55 bytes: terminator and length fit in one block
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'(i));
    send_msg(1'b0);
    build_exp();
    drain_check("len55");
    chk("len55_pad", 512'(got_q[0].data[71:64]), 512'(8'h80));
    chk("len55_len", 512'(got_q[0].data[63:0]), 512'(64'h1B8));

    // 56 bytes: length spills into a second block
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'(i + 3));
    send_msg(1'b0);
    build_exp();
    drain_check("len56");
    chk("len56_pad", 512'(got_q[0].data[63:0]), 512'(64'h8000000000000000));
    chk("len56_blk2", got_q[1].data, 512'(64'h1C0));
    chk("len56_gap", 512'(got_q[1].rise), 512'(got_q[0].hs + 1));

    // 64 bytes: data-only block then a 0x80-led block
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(255 - i));
    send_msg(1'b0);
    build_exp();
    drain_check("len64");
    ref_blk = '0;
    ref_blk[511:504] = 8'h80;
    ref_blk[63:0]    = 64'h200;
    chk("len64_blk2", got_q[1].data, ref_blk);
    chk("len64_rate", 512'(acc_q[63] - acc_q[0]), 512'(63));
    chk("len64_lat", 512'(got_q[0].rise), 512'(acc_q[63]));

    // Backpressure: block held, nothing consumed while stalled
    blk_ready = 1'b0;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    step();
    d0 = blk_data;
    l0 = blk_last;
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0; in_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_data_stable", blk_data, d0);
      chk("bp_last_stable", 512'(blk_last), 512'(l0));
      chk("bp_in_ready", 512'(in_ready), 512'(0));
      chk("bp_valid", 512'(blk_valid), 512'(1));
    end
    in_valid = 1'b0;
    blk_ready = 1'b1;
    build_exp();
    drain_check("bp_abc");
    chk("bp_abc_const", got_q[0].data, abc_blk);

    // Reset mid-message (20 bytes) and mid-EMIT (64 bytes, stalled)
    for (int ph = 0; ph < 2; ph++) begin
      int nb = (ph == 0) ? 20 : 64;
      blk_ready = (ph == 0);
      for (int i = 0; i < nb; i++) send_beat(8'($urandom), 1'b0, 1'b0);
      step();
      rst = 1'b1;
      step();
      step();
      chk_reset_outputs("midreset");
      rst = 1'b0;
      blk_ready = 1'b1;
      step();
      msg = '{8'h61, 8'h62, 8'h63};
      send_msg(1'b0);
      build_exp();
      drain_check("rst_abc");
      chk("rst_abc_const", got_q[0].data, abc_blk);
    end

    // Randomized messages with gaps, illegal empty beats and backpressure
    rbp = 1'b1;
    for (int t = 0; t < 12; t++) begin
      int n = $urandom_range(0, 140);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      send_msg(1'b1);
      build_exp();
      drain_check($sformatf("rand%0d", t));
    end
    rbp = 1'b0;
    blk_ready = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
